// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add step per clock, LSB first.
// The result is published on sum/carry only when the last bit completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [WIDTH-1:0] psum;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] psum_next;

    assign s         = a_sh[0] ^ b_sh[0] ^ c;
    assign c_next    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign psum_next = {s, psum[WIDTH-1:1]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            c     <= 1'b0;
            psum  <= '0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        psum  <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_next;
                    psum <= psum_next;
                    cnt  <= cnt + CW'(1);
                    // Final bit: publish the completed word, including this step's sum bit.
                    if (cnt == LAST) begin
                        sum   <= psum_next;
                        carry <= c_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: start  input  1  request to begin an addition; honoured only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepting edge.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  single-cycle pulse marking a valid result.
REQ-010 Port: sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-011 Port: carry  output  1  registered carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE->RUN SHALL occur on a rising edge with start=1; a, b and cin SHALL load into shift registers A_sh and B_sh and a carry flip-flop C on that edge.
REQ-014 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL be cleared on the accepting edge.
REQ-015 Each RUN edge SHALL perform one full-add step:
  - s = A_sh[0]^B_sh[0]^C
  - C <= majority(A_sh[0],B_sh[0],C)
  - A_sh and B_sh shift right by one
  - s shifts into the MSB of the partial-sum register
  - counter increments
REQ-016 Exactly WIDTH RUN edges SHALL occur. On the WIDTH-th edge:
  - sum and carry are updated from the partial-sum register and C
  - state moves to DONE
REQ-017 sum and carry SHALL change only on the completing edge (or reset). They SHALL hold their previous values throughout RUN and until the next completion.
REQ-018 done SHALL be 1 exactly during the DONE cycle, then DONE->IDLE unconditionally on the next edge.
REQ-019 Latency SHALL be WIDTH+1 cycles: start accepted at edge k gives done=1 in the cycle following edge k+WIDTH.
REQ-020 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored in RUN and in DONE, and operand changes SHALL have no effect after capture. No request is queued: start held high through DONE is accepted on the first IDLE edge.
REQ-022 The result SHALL be correct for all operand extremes, including all-zeros, all-ones and cin=1 with a+b=2^WIDTH-1.

Reset
REQ-023 On any edge with rst=1, regardless of state:
  - state <= IDLE
  - busy, done, sum, carry, counter, A_sh, B_sh, C, partial sum <= 0
REQ-024 rst SHALL take priority over start on the same edge. An addition in progress SHALL be aborted with no done pulse, and no stale result SHALL appear afterwards.
REQ-025 After rst deasserts, a start on the first following edge SHALL be accepted.

Verification (WIDTH=8 unless noted)
REQ-026 The bench SHALL cover: start with a=8'h00, b=8'h00, cin=0 -> done one cycle after 8 RUN edges, sum=8'h00, carry=0; busy high for exactly 8 cycles.
REQ-027 The bench SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1; and a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, carry=1.
REQ-028 The bench SHALL cover: a=8'd100, b=8'd27, cin=0 -> sum=8'd127, carry=0. Operands changed to 8'hFF during RUN SHALL not affect the result, and sum SHALL hold the previous result until completion.
REQ-029 The bench SHALL cover start pulsed during RUN and held high through DONE: the extra pulses are ignored, exactly one done per accepted start, and the second addition starts on the first IDLE edge.
REQ-030 The bench SHALL cover rst asserted at RUN edge 4: the next cycle shows busy=0, done=0, sum=0, carry=0, and no done pulse follows. A subsequent a=8'h0F, b=8'hF0, cin=1 -> sum=8'h00, carry=1.
REQ-031 The bench SHALL cover exhaustive WIDTH=2 operation: all 32 (a,b,cin) combinations match a reference model.
